mm_iddmm_io: RTL and testbench
==============================

Name: mm_iddmm_io

Overview:
Operand/result adapter wrapped around the word-serial IDDMM Montgomery top (mm_start / mm_x / mm_y / mm_result interface).
- Accepts one full-width operand pair (x, y of K*N bits) through a valid/ready handshake.
- Streams y words, pulses start, then streams x words, low word first.
- Collects the N result words back into one K*N-bit result, held under a valid/ready handshake.
- Sits between the Paillier/RSA sequencing logic and the Montgomery core.

Parameters:
K, 128, bits per word
N, 16, words per operand
CNT_W, $clog2(N+1), word counter width
TIMEOUT_CYCLES, 65536, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  adapter can accept an operand pair
in_x  input  K*N  multiplicand; word i = bits [i*K +: K]
in_y  input  K*N  multiplier; same packing
mm_start  output  1  one-cycle start pulse to the core
mm_x  output  K  x word to the core
mm_x_valid  output  1  x word strobe
mm_y  output  K  y word to the core
mm_y_valid  output  1  y word strobe
mm_result  input  K  result word from the core
mm_valid  input  1  result word strobe
res_data  output  K*N  collected result; word i = bits [i*K +: K]
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
busy  output  1  high in every state except IDLE
timeout_err  output  1  one-cycle watchdog abort pulse

Behaviour:
- Reset (async, rst=1): state IDLE, all counters 0. Outputs: in_ready=1; mm_start=0, mm_x_valid=0, mm_y_valid=0, res_valid=0, busy=0, timeout_err=0; mm_x, mm_y and res_data all zero. All outputs are registered.
- IDLE: in_ready=1. On in_valid & in_ready (cycle 0), latch in_x and in_y, then go to LOAD_Y. in_ready is low from cycle 1 until the state returns to IDLE.
- LOAD_Y, cycles 1..N:
  - mm_y_valid=1 with mm_y = y word 0,1,...,N-1 on consecutive cycles.
  - The core shifts these into its y store, so word 0 must be sent first.
- START, cycle N+1: mm_start=1 for exactly one cycle.
- LOAD_X, cycles N+2..2N+1: mm_x_valid=1 with mm_x = x word 0..N-1 on consecutive cycles, no gaps.
- mm_x and mm_y hold their last value when their strobe is low, and return to 0 in IDLE.
- COLLECT:
  - Entered at cycle 2N+2.
  - Each mm_valid writes mm_result into res_data word[rcnt]; rcnt then increments.
  - mm_valid pulses may be non-consecutive.
  - When the Nth word is captured, go to DONE; res_valid rises the next cycle.
- mm_valid outside COLLECT is ignored: no write, no counter change.
- DONE: res_valid=1, res_data stable, until res_ready is sampled high; then res_valid=0 and the state returns to IDLE. in_ready rises in the cycle after the handshake, so there is no same-cycle re-accept.
- busy = (state != IDLE).
- Reset asserted mid-operation aborts immediately to the reset values. Partial results are discarded and no strobes are emitted after reset.
- in_valid while in_ready=0 is ignored; the source must hold its data until accepted.
- Minimum latency from accept to res_valid = 2N+3 cycles plus the core's compute time.

Optional Feature:
Macro MM_IDDMM_IO_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to COLLECT and on every mm_valid, and increments on every other COLLECT cycle.
  - On reaching TIMEOUT_CYCLES: timeout_err=1 for one cycle, res_valid is never asserted, res_data is zeroed, and the state goes to IDLE.
- Undefined: no counter is built, timeout_err is tied to 0, and COLLECT waits indefinitely.

Test Plan:
All scenarios use the bench configuration K=8, N=4, TIMEOUT_CYCLES=16.
- Basic stream: in_x=32'h04030201, in_y=32'h44332211, accepted at cycle 0 -> mm_y 11,22,33,44 at cycles 1-4; mm_start at cycle 5; mm_x 01,02,03,04 at cycles 6-9; in_ready=0 and busy=1 throughout.
- Collect: mm_valid with AA,BB,CC,DD at cycles 20, 21, 25, 30 -> res_valid at cycle 31, res_data=32'hDDCCBBAA.
- Backpressure: hold res_ready=0 for 5 cycles -> res_valid and res_data stable; in_ready=0. On res_ready=1, res_valid drops next cycle and in_ready=1 the cycle after the handshake.
- Stray strobe: mm_valid with 5A during LOAD_X -> ignored; the final res_data equals the four words sent during COLLECT.
- Reset mid-LOAD_X (rst=1 at cycle 7) -> all strobes 0, in_ready=1, busy=0. A new pair accepted after release streams from word 0.
- With MM_IDDMM_IO_TIMEOUT_EN: two result words, then silence -> timeout_err pulse exactly 16 cycles after the last mm_valid, res_valid stays 0, return to IDLE. Without the macro: res_valid stays 0, busy stays 1, timeout_err stays 0.

Source files
------------

// File: rtl/mm_iddmm_io.sv
// Operand/result adapter for the word-serial IDDMM Montgomery core.
// Accepts one x/y operand pair and streams y words, a start pulse, then x words.
// Gathers N result words from the core and holds them under a valid/ready handshake.
// Optional collect watchdog: define MM_IDDMM_IO_TIMEOUT_EN.
module mm_iddmm_io #(
    parameter int unsigned K              = 128,
    parameter int unsigned N              = 16,
    parameter int unsigned CNT_W          = $clog2(N + 1),
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [K*N-1:0] in_x,
    input  logic [K*N-1:0] in_y,
    output logic           mm_start,
    output logic [K-1:0]   mm_x,
    output logic           mm_x_valid,
    output logic [K-1:0]   mm_y,
    output logic           mm_y_valid,
    input  logic [K-1:0]   mm_result,
    input  logic           mm_valid,
    output logic [K*N-1:0] res_data,
    output logic           res_valid,
    input  logic           res_ready,
    output logic           busy,
    output logic           timeout_err
);

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(N - 1);

    // The watchdog compare needs at least two cycles of headroom.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        StIdle,
        StLoadY,
        StStart,
        StLoadX,
        StCollect,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [K*N-1:0]   x_q, x_d;
    logic [K*N-1:0]   y_q, y_d;
    logic [K*N-1:0]   res_data_q, res_data_d;
    logic [K-1:0]     mm_x_q, mm_x_d;
    logic [K-1:0]     mm_y_q, mm_y_d;
    logic             mm_x_valid_q, mm_x_valid_d;
    logic             mm_y_valid_q, mm_y_valid_d;
    logic             mm_start_q, mm_start_d;
    logic             res_valid_q, res_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             timeout_err_q, timeout_err_d;

`ifdef MM_IDDMM_IO_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    // Outputs are registered, so fire one count early: the pulse then appears
    // exactly TIMEOUT_CYCLES cycles after the last result strobe.
    localparam logic [WD_W-1:0] WdFire = WD_W'(TIMEOUT_CYCLES - 2);
    logic [WD_W-1:0] wd_q, wd_d;

    // Watchdog counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    // State, counter, operand and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            res_data_q    <= '0;
            mm_x_q        <= '0;
            mm_y_q        <= '0;
            mm_x_valid_q  <= 1'b0;
            mm_y_valid_q  <= 1'b0;
            mm_start_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            in_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            x_q           <= x_d;
            y_q           <= y_d;
            res_data_q    <= res_data_d;
            mm_x_q        <= mm_x_d;
            mm_y_q        <= mm_y_d;
            mm_x_valid_q  <= mm_x_valid_d;
            mm_y_valid_q  <= mm_y_valid_d;
            mm_start_q    <= mm_start_d;
            res_valid_q   <= res_valid_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next state, word counter, operand latch and result assembly
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        x_d           = x_q;
        y_d           = y_q;
        res_data_d    = res_data_q;
        timeout_err_d = 1'b0;
`ifdef MM_IDDMM_IO_TIMEOUT_EN
        wd_d          = '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready_q) begin
                    x_d     = in_x;
                    y_d     = in_y;
                    cnt_d   = '0;
                    state_d = StLoadY;
                end
            end
            StLoadY: begin
                if (cnt_q == LastIdx) begin
                    cnt_d   = '0;
                    state_d = StStart;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StLoadX;
            end
            StLoadX: begin
                if (cnt_q == LastIdx) begin
                    cnt_d   = '0;
                    state_d = StCollect;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCollect: begin
                if (mm_valid) begin
                    res_data_d[cnt_q*K +: K] = mm_result;
                    if (cnt_q == LastIdx) begin
                        cnt_d   = '0;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`ifdef MM_IDDMM_IO_TIMEOUT_EN
                end else if (wd_q == WdFire) begin
                    // Core went silent: drop the partial result and abort.
                    res_data_d    = '0;
                    cnt_d         = '0;
                    timeout_err_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    wd_d = wd_q + 1'b1;
`endif
                end
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered outputs derived from the upcoming state
    always_comb begin
        mm_y_valid_d = (state_d == StLoadY);
        mm_x_valid_d = (state_d == StLoadX);
        mm_start_d   = (state_d == StStart);
        res_valid_d  = (state_d == StDone);
        in_ready_d   = (state_d == StIdle);
        busy_d       = (state_d != StIdle);
        mm_y_d       = mm_y_q;
        mm_x_d       = mm_x_q;
        if (state_d == StIdle) begin
            mm_y_d = '0;
            mm_x_d = '0;
        end else begin
            if (state_d == StLoadY) begin
                mm_y_d = y_d[cnt_d*K +: K];
            end
            if (state_d == StLoadX) begin
                mm_x_d = x_d[cnt_d*K +: K];
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign mm_start    = mm_start_q;
    assign mm_x        = mm_x_q;
    assign mm_x_valid  = mm_x_valid_q;
    assign mm_y        = mm_y_q;
    assign mm_y_valid  = mm_y_valid_q;
    assign res_data    = res_data_q;
    assign res_valid   = res_valid_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mm_iddmm_io.sv
// Directed bench for mm_iddmm_io with K=8, N=4, TIMEOUT_CYCLES=16.
// Cycle 0 is the cycle whose closing edge accepts the operand pair.
module tb_mm_iddmm_io;

    localparam int unsigned K  = 8;
    localparam int unsigned N  = 4;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_x;
    logic [31:0]   in_y;
    logic          mm_start;
    logic [7:0]    mm_x;
    logic          mm_x_valid;
    logic [7:0]    mm_y;
    logic          mm_y_valid;
    logic [7:0]    mm_result;
    logic          mm_valid;
    logic [31:0]   res_data;
    logic          res_valid;
    logic          res_ready;
    logic          busy;
    logic          timeout_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] xv;
    logic [31:0] yv;

    mm_iddmm_io #(
        .K              (K),
        .N              (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .mm_start    (mm_start),
        .mm_x        (mm_x),
        .mm_x_valid  (mm_x_valid),
        .mm_y        (mm_y),
        .mm_y_valid  (mm_y_valid),
        .mm_result   (mm_result),
        .mm_valid    (mm_valid),
        .res_data    (res_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic accept(input logic [31:0] x, input logic [31:0] y);
        in_x     = x;
        in_y     = y;
        in_valid = 1'b1;
        chk("accept_in_ready", {31'd0, in_ready}, 32'd1);
        cyc = 0;
        step();
        in_valid = 1'b0;
    endtask

    // Advance to cycle c, then present one result word for that cycle.
    task automatic drive_word(input int c, input logic [7:0] d);
        while (cyc < c) step();
        mm_result = d;
        mm_valid  = 1'b1;
        chk("collect_no_early_valid", {31'd0, res_valid}, 32'd0);
        step();
        mm_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        mm_result = '0;
        mm_valid  = 1'b0;
        res_ready = 1'b0;
        #12;
        chk("rst_in_ready",  {31'd0, in_ready},    32'd1);
        chk("rst_busy",      {31'd0, busy},        32'd0);
        chk("rst_start",     {31'd0, mm_start},    32'd0);
        chk("rst_xv",        {31'd0, mm_x_valid},  32'd0);
        chk("rst_yv",        {31'd0, mm_y_valid},  32'd0);
        chk("rst_res_valid", {31'd0, res_valid},   32'd0);
        chk("rst_timeout",   {31'd0, timeout_err}, 32'd0);
        chk("rst_mm_x",      {24'd0, mm_x},        32'd0);
        chk("rst_mm_y",      {24'd0, mm_y},        32'd0);
        chk("rst_res_data",  res_data,             32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Basic stream with a stray result strobe during LOAD_X.
        xv = 32'h04030201;
        yv = 32'h44332211;
        accept(xv, yv);
        for (int i = 0; i < 4; i++) begin
            chk("ld_y_valid", {31'd0, mm_y_valid}, 32'd1);
            chk("ld_y_word",  {24'd0, mm_y},       {24'd0, yv[i*8 +: 8]});
            chk("ld_y_start", {31'd0, mm_start},   32'd0);
            chk("ld_y_xv",    {31'd0, mm_x_valid}, 32'd0);
            chk("ld_y_ready", {31'd0, in_ready},   32'd0);
            chk("ld_y_busy",  {31'd0, busy},       32'd1);
            step();
        end
        chk("start_pulse", {31'd0, mm_start},   32'd1);
        chk("start_yv",    {31'd0, mm_y_valid}, 32'd0);
        chk("start_y_hold", {24'd0, mm_y},      32'h44);
        chk("start_busy",  {31'd0, busy},       32'd1);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("ld_x_valid", {31'd0, mm_x_valid}, 32'd1);
            chk("ld_x_word",  {24'd0, mm_x},       {24'd0, xv[i*8 +: 8]});
            chk("ld_x_start", {31'd0, mm_start},   32'd0);
            chk("ld_x_ready", {31'd0, in_ready},   32'd0);
            if (cyc == 7) begin
                mm_result = 8'h5A;
                mm_valid  = 1'b1;
            end
            step();
            mm_valid = 1'b0;
        end
        chk("collect_xv",     {31'd0, mm_x_valid}, 32'd0);
        chk("collect_x_hold", {24'd0, mm_x},       32'h04);
        chk("collect_start",  {31'd0, mm_start},   32'd0);
        chk("collect_busy",   {31'd0, busy},       32'd1);

        drive_word(20, 8'hAA);
        drive_word(21, 8'hBB);
        drive_word(25, 8'hCC);
        drive_word(30, 8'hDD);
        chk("done_cycle",     cyc,                   32'd31);
        chk("done_res_valid", {31'd0, res_valid},    32'd1);
        chk("done_res_data",  res_data,              32'hDDCCBBAA);

        // Hold the result under backpressure.
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_res_valid", {31'd0, res_valid}, 32'd1);
            chk("bp_res_data",  res_data,           32'hDDCCBBAA);
            chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
            chk("bp_busy",      {31'd0, busy},      32'd1);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("hs_res_valid", {31'd0, res_valid}, 32'd0);
        chk("hs_in_ready",  {31'd0, in_ready},  32'd1);
        chk("hs_busy",      {31'd0, busy},      32'd0);
        chk("hs_mm_x_zero", {24'd0, mm_x},      32'd0);

        // Reset asserted in the middle of LOAD_X.
        accept(32'h0D0C0B0A, 32'h1D1C1B1A);
        while (cyc < 6) step();
        chk("rx_word0", {24'd0, mm_x}, 32'h0A);
        step();
        chk("rx_word1", {24'd0, mm_x}, 32'h0B);
        rst = 1'b1;
        #1;
        chk("rx_xv",       {31'd0, mm_x_valid}, 32'd0);
        chk("rx_yv",       {31'd0, mm_y_valid}, 32'd0);
        chk("rx_start",    {31'd0, mm_start},   32'd0);
        chk("rx_in_ready", {31'd0, in_ready},   32'd1);
        chk("rx_busy",     {31'd0, busy},       32'd0);
        chk("rx_mm_x",     {24'd0, mm_x},       32'd0);
        step();
        chk("rx_hold_xv",  {31'd0, mm_x_valid}, 32'd0);
        rst = 1'b0;
        step();

        xv = 32'h24232221;
        yv = 32'h34333231;
        accept(xv, yv);
        chk("rx2_y0", {24'd0, mm_y}, 32'h31);
        while (cyc < 6) step();
        chk("rx2_xv", {31'd0, mm_x_valid}, 32'd1);
        chk("rx2_x0", {24'd0, mm_x},       32'h21);
        drive_word(10, 8'hE1);
        drive_word(11, 8'hE2);
        drive_word(12, 8'hE3);
        drive_word(13, 8'hE4);
        chk("rx2_res_valid", {31'd0, res_valid}, 32'd1);
        chk("rx2_res_data",  res_data,           32'hE4E3E2E1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("rx2_idle", {31'd0, in_ready}, 32'd1);

        // Two result words, then the core goes silent.
        accept(32'h55667788, 32'h11223344);
        drive_word(10, 8'h01);
        drive_word(11, 8'h02);
`ifdef MM_IDDMM_IO_TIMEOUT_EN
        while (cyc < 27) begin
            chk("to_quiet", {31'd0, timeout_err}, 32'd0);
            step();
        end
        chk("to_pulse",     {31'd0, timeout_err}, 32'd1);
        chk("to_res_valid", {31'd0, res_valid},   32'd0);
        chk("to_res_data",  res_data,             32'd0);
        chk("to_busy",      {31'd0, busy},        32'd0);
        chk("to_in_ready",  {31'd0, in_ready},    32'd1);
        step();
        chk("to_one_shot",  {31'd0, timeout_err}, 32'd0);
`else
        while (cyc < 40) begin
            chk("nto_res_valid", {31'd0, res_valid},   32'd0);
            chk("nto_busy",      {31'd0, busy},        32'd1);
            chk("nto_timeout",   {31'd0, timeout_err}, 32'd0);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("nto_rst_idle", {31'd0, busy}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
